// File: rtl/lfsr_pkg.sv
// Shared LFSR constants, scheduler state encoding and the team step function.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 8;
  localparam logic [LFSR_WIDTH-1:0] TAPS_UP = 8'h63;
  localparam logic [LFSR_WIDTH-1:0] TAPS_DN = 8'hB1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // XNOR LFSR step: up shifts right with feedback into the MSB, down shifts left into the LSB.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] count,
                                                      input logic dir);
    if (dir) begin
      return {~^(count & TAPS_UP), count[LFSR_WIDTH-1:1]};
    end
    return {count[LFSR_WIDTH-2:0], ~^(count & TAPS_DN)};
  endfunction

endpackage

// File: rtl/lfsr_timer_sched_core.sv
// LFSR count register: cleared on load, advanced one XNOR step per step strobe.
module lfsr_core #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS_UP = 8'h63,
  parameter logic [WIDTH-1:0] TAPS_DN = 8'hB1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] next_up;
  logic [WIDTH-1:0] next_dn;

  assign next_up = {~^(count & TAPS_UP), count[WIDTH-1:1]};
  assign next_dn = {count[WIDTH-2:0], ~^(count & TAPS_DN)};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      count <= dir ? next_up : next_dn;
    end
  end

endmodule

// File: rtl/lfsr_timer_sched.sv
// Round-robin scheduler sharing one LFSR interval counter among NREQ requesters.
module lfsr_timer_sched #(
  parameter int unsigned      WIDTH   = lfsr_pkg::LFSR_WIDTH,
  parameter int unsigned      NREQ    = 4,
  parameter logic [WIDTH-1:0] TAPS_UP = lfsr_pkg::TAPS_UP,
  parameter logic [WIDTH-1:0] TAPS_DN = lfsr_pkg::TAPS_DN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*WIDTH-1:0] req_term,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  import lfsr_pkg::*;

  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Last step index of a full maximal-length period (the lock-up state is never visited).
  localparam logic [WIDTH-1:0] STEP_MAX = WIDTH'((64'd1 << WIDTH) - 64'd2);

  state_t            state, state_next;
  logic [SELW-1:0]   sel, sel_next;
  logic              dir, dir_next;
  logic [WIDTH-1:0]  term, term_next;
  logic [SELW-1:0]   rr_ptr, rr_ptr_next;
  logic [WIDTH-1:0]  step_cnt, step_cnt_next;
  logic [NREQ-1:0]   grant_next, done_next, err_next;
  logic              load, step;
  logic [SELW-1:0]   pick, sel_succ;
  logic              pick_valid;
  int unsigned       idx;
  logic [WIDTH-1:0]  term_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_term
    assign term_arr[g] = req_term[g*WIDTH +: WIDTH];
  end

  assign sel_succ = (sel == SELW'(NREQ - 1)) ? '0 : sel + SELW'(1);

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!pick_valid && req[SELW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = SELW'(idx);
      end
    end
  end

  always_comb begin
    state_next    = state;
    sel_next      = sel;
    dir_next      = dir;
    term_next     = term;
    rr_ptr_next   = rr_ptr;
    step_cnt_next = step_cnt;
    grant_next    = grant;
    done_next     = '0;
    err_next      = '0;
    load          = 1'b0;
    step          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          sel_next   = pick;
          dir_next   = req_dir[pick];
          term_next  = term_arr[pick];
          grant_next = NREQ'(1) << pick;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load          = 1'b1;
        step_cnt_next = '0;
        state_next    = RUN;
      end
      RUN: begin
        // Abort has priority over a match seen in the same cycle.
        if (!req[sel]) begin
          grant_next  = '0;
          rr_ptr_next = sel_succ;
          state_next  = IDLE;
        end else if (count == term) begin
          grant_next = '0;
          done_next  = NREQ'(1) << sel;
          state_next = DONE;
        end else if (step_cnt == STEP_MAX) begin
          grant_next = '0;
          err_next   = NREQ'(1) << sel;
          state_next = DONE;
        end else begin
          step          = 1'b1;
          step_cnt_next = step_cnt + WIDTH'(1);
        end
      end
      DONE: begin
        rr_ptr_next = sel_succ;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      dir      <= 1'b0;
      term     <= '0;
      rr_ptr   <= '0;
      step_cnt <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      sel      <= sel_next;
      dir      <= dir_next;
      term     <= term_next;
      rr_ptr   <= rr_ptr_next;
      step_cnt <= step_cnt_next;
      grant    <= grant_next;
      done     <= done_next;
      err      <= err_next;
      busy     <= (state_next != IDLE);
    end
  end

  lfsr_core #(
    .WIDTH  (WIDTH),
    .TAPS_UP(TAPS_UP),
    .TAPS_DN(TAPS_DN)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .step (step),
    .dir  (dir),
    .count(count)
  );

endmodule

// File: tb/tb_lfsr_timer_sched.sv
// Bench for lfsr_timer_sched: vector table, randomized transactions against a reference model, corner sequences.
module tb_lfsr_timer_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_dir;
  logic [31:0] req_term;
  logic [3:0]  grant, done, err;
  logic        busy;
  logic [7:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         who;
    logic       dir;
    logic [7:0] term;
    int         exp_cycle;
    logic       exp_err;
  } vec_t;

  lfsr_timer_sched #(.WIDTH(8), .NREQ(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_dir (req_dir),
    .req_term(req_term),
    .grant   (grant),
    .done    (done),
    .err     (err),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference LFSR step from parity of the tapped bits.
  function automatic logic [7:0] ref_step(input logic [7:0] c, input logic up);
    logic [7:0] t;
    int ones;
    logic fb;
    t = c & (up ? 8'h63 : 8'hB1);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(t[i]);
    fb = (ones % 2 == 0);
    if (up) return 8'((int'(fb) << 7) | (int'(c) >> 1));
    return 8'((int'(c) << 1) | int'(fb));
  endfunction

  // Steps from 0 to term within one full period, or -1 if never reached.
  function automatic int ref_steps(input logic up, input logic [7:0] term);
    logic [7:0] c;
    c = 8'h00;
    for (int s = 0; s < 255; s++) begin
      if (c == term) return s;
      c = ref_step(c, up);
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    req_dir  = '0;
    req_term = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One lone request from IDLE; cycle 0 is the edge that samples it.
  task automatic run_txn(input int who, input logic d, input logic [7:0] t,
                         input int exp_cycle, input logic exp_err, input string tag);
    logic [7:0] m;
    logic [3:0] g;
    logic       seen;
    int         c;
    g        = 4'b0001 << who;
    req      = g;
    req_dir  = 4'($urandom);
    req_dir[who] = d;
    req_term = $urandom;
    req_term[who*8 +: 8] = t;
    m    = 8'h00;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 300) begin
      @(posedge clk);
      #1;
      c++;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      if (done == 4'b0 && err == 4'b0) begin
        chk({tag, " grant"}, 32'(grant), 32'(g));
        if (c >= 2) begin
          chk({tag, " count"}, 32'(count), 32'(m));
          m = ref_step(m, d);
        end
      end else begin
        seen = 1'b1;
        chk({tag, " cycle"}, 32'(c), 32'(exp_cycle));
        chk({tag, " done"}, 32'(done), exp_err ? 32'd0 : 32'(g));
        chk({tag, " err"}, 32'(err), exp_err ? 32'(g) : 32'd0);
        chk({tag, " grant_off"}, 32'(grant), 32'd0);
        if (!exp_err) chk({tag, " final_count"}, 32'(count), 32'(t));
      end
    end
    chk({tag, " pulse_seen"}, 32'(seen), 32'd1);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    logic [3:0] pend;
    int         ptr, expw, k, who, cyc;
    logic       got;
    logic       d;
    logic [7:0] t;

    vecs[0] = '{0, 1'b1, 8'h60, 6, 1'b0};
    vecs[1] = '{1, 1'b0, 8'h05, 6, 1'b0};
    vecs[2] = '{2, 1'b1, 8'h00, 3, 1'b0};
    vecs[3] = '{3, 1'b0, 8'h00, 3, 1'b0};
    vecs[4] = '{0, 1'b1, 8'h80, 4, 1'b0};
    vecs[5] = '{1, 1'b0, 8'h01, 4, 1'b0};
    vecs[6] = '{1, 1'b1, 8'hC0, 5, 1'b0};
    vecs[7] = '{2, 1'b1, 8'hFF, 257, 1'b1};
    vecs[8] = '{3, 1'b0, 8'hFF, 257, 1'b1};

    do_reset();
    chk("reset count", 32'(count), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done_err", 32'({done, err}), 32'd0);

    for (int i = 0; i < 9; i++) run_txn(vecs[i].who, vecs[i].dir, vecs[i].term,
                                        vecs[i].exp_cycle, vecs[i].exp_err, $sformatf("vec%0d", i));
    chk("idle after lockup", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      who = int'($urandom_range(0, 3));
      d   = 1'($urandom_range(0, 1));
      t   = 8'($urandom);
      k   = ref_steps(d, t);
      run_txn(who, d, t, (k < 0) ? 257 : 3 + k, k < 0, $sformatf("rnd%0d", i));
    end

    // All four held: strict rotation 0,1,2,3,0.
    do_reset();
    req      = 4'hF;
    req_dir  = 4'($urandom);
    req_term = '0;
    expw = 0;
    for (int j = 0; j < 5; j++) begin
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(posedge clk);
        #1;
        chk("rr grant onehot0", 32'($onehot0(grant)), 32'd1);
        if (done != 4'b0) got = 1'b1;
      end
      chk("rr pulse_seen", 32'(got), 32'd1);
      chk($sformatf("rr order %0d", j), 32'(done), 32'(4'b0001 << expw));
      expw = (expw + 1) % 4;
    end
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    ptr = 1;

    // Random pending masks; each requester drops its request once served.
    for (int r = 0; r < 6; r++) begin
      pend     = 4'($urandom_range(1, 15));
      req      = pend;
      req_dir  = 4'($urandom);
      req_term = '0;
      while (pend != 4'b0) begin
        expw = -1;
        for (int s = 0; s < 4; s++)
          if (expw < 0 && pend[(ptr + s) % 4]) expw = (ptr + s) % 4;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
          @(posedge clk);
          #1;
          if (done != 4'b0) got = 1'b1;
        end
        chk("mask pulse_seen", 32'(got), 32'd1);
        chk($sformatf("mask%0d order", r), 32'(done), 32'(4'b0001 << expw));
        pend[expw] = 1'b0;
        req = pend;
        ptr = (expw + 1) % 4;
      end
      @(posedge clk);
      #1;
    end

    // Abort: drop req[2] mid-run while req[0] waits.
    do_reset();
    req = 4'b0100;
    req_dir = 4'b0100;
    req_term = 32'h00FF_0000;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    req = 4'b0001;
    @(posedge clk);
    #1;
    chk("abort grant", 32'(grant), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort pulses", 32'({done, err}), 32'd0);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("abort no err", 32'(err), 32'd0);
      if (done != 4'b0) got = 1'b1;
    end
    chk("abort next served", 32'(done), 32'd1);
    chk("abort next latency", 32'(cyc), 32'd3);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset in the middle of a run.
    req = 4'b0010;
    req_dir = 4'b0010;
    req_term = 32'h0000_FF00;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    chk("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset count", 32'(count), 32'd0);
    chk("midreset grant", 32'(grant), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset pulses", 32'({done, err}), 32'd0);
    reset = 1'b0;
    req = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("post-reset pulses", 32'({done, err}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
